reg_select_seq: RTL
===================

# reg_select_seq

Parametrised, sequenced successor to the combinational register select/encode logic. Latches an instruction word through a valid/ready handshake, then steps through that instruction's register phases (reads, then write) under datapath control. Each phase drives one-hot register-file enables and the sign-extended immediate from registered state. Sits between the control unit and the register file; the control unit no longer hand-drives Gra/Grb/Grc.

## Interface
Parameters:
- NUM_REGS, 16, register count; power of two, 2..16; REG_BITS = clog2(NUM_REGS)
- IR_WIDTH, 32, instruction width
- RA_LSB, 23, LSB of Ra field (REG_BITS wide)
- RB_LSB, 19, LSB of Rb field
- RC_LSB, 15, LSB of Rc field
- IMM_WIDTH, 19, immediate width, IR[IMM_WIDTH-1:0]; must be < IR_WIDTH

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-low reset
- IR  in  IR_WIDTH  instruction word
- ir_valid  in  1  IR and mode are valid
- ir_ready  out  1  unit can accept (high only in IDLE)
- mode  in  2  00 R-type, 01 I-type, 10 store, 11 branch; latched with IR
- ba_mode  in  1  base-address semantics for read phases
- step  in  1  datapath has consumed the current phase
- SERin  out  NUM_REGS  one-hot register write enable
- SERout  out  NUM_REGS  one-hot register read enable
- zero_src  out  1  read phase selects R0 under ba_mode; datapath drives constant 0
- phase  out  2  0 idle, 1 first read, 2 second read, 3 write
- done  out  1  one-cycle pulse, sequence complete
- C_sign_extended  out  IR_WIDTH  sign-extended immediate of latched IR
- stall  out  1  read phase blocked by scoreboard (0 without macro)
- wr_defer  in  1  write is deferred; sampled on write-phase step
- wr_commit  in  1  deferred write has completed
- wr_index  in  REG_BITS  register index for wr_commit

## Operation
- States: IDLE, RD0, RD1, WR. Accept on ir_valid & ir_ready: latch IR and mode; the next state is the first phase of the mode.
- Phase sequence per mode:
  - R-type: RD0 = Rb, RD1 = Rc, WR = Ra.
  - I-type: RD0 = Rb, WR = Ra.
  - Store: RD0 = Rb (base), RD1 = Ra (data), no WR.
  - Branch: RD0 = Ra only.
- Each phase holds until step = 1 at a clock edge, then advances. step in IDLE is ignored.
- After the last phase's step, the state returns to IDLE and done is high for that next cycle. ir_ready is high in the same cycle, so back-to-back accepts are possible.
- Read phases: SERout = one-hot(index); SERin = 0.
- Write phase: SERin = one-hot(Ra); SERout = 0. A write to R0 is allowed.
- IDLE: SERin = SERout = 0.
- ba_mode in a read phase with selected index 0: SERout = 0 and zero_src = 1. Otherwise zero_src = 0. ba_mode is sampled live.
- C_sign_extended = {(IR_WIDTH-IMM_WIDTH) copies of latched IR[IMM_WIDTH-1], latched IR[IMM_WIDTH-1:0]}. It holds after done until the next accept.
- Outputs derive only from registered state and the latched IR. There is no combinational path from IR/mode to any output.
- ir_valid outside IDLE is ignored; IR is not re-latched.

## Timing
- Reset (clear low, any time, including mid-sequence):
  - state IDLE, latched IR/mode = 0.
  - SERin, SERout, zero_src, done, stall, phase = 0; C_sign_extended = 0; ir_ready = 1; scoreboard cleared.
- Accept edge to first phase visible: 1 cycle.
- Minimum sequence (step held high):
  - R-type: accept + 3 cycles, done on the 4th cycle after accept.
  - Branch: done 2 cycles after accept.
- step held low holds the phase and its outputs indefinitely.

## Configuration
- SELECT_SCOREBOARD_EN defined: adds a NUM_REGS busy vector.
  - A write-phase step with wr_defer = 1 sets busy[Ra].
  - wr_commit clears busy[wr_index].
  - Set and clear of the same index on the same edge: clear wins.
  - A read phase whose selected register is busy holds stall = 1 and SERout = 0, and ignores step until the register is clear. zero_src reads of R0 never stall.
- SELECT_SCOREBOARD_EN undefined: no busy state; stall is tied to 0; wr_defer, wr_commit and wr_index are ignored.

## Test plan
- Sequencing: R-type with Ra=3, Rb=5, Rc=9, step high → phase 1/2/3 with SERout=0x0020, then 0x0200, then SERin=0x0008; done pulse; ir_ready back to 1.
- Immediate: I-type with IR[18:0]=0x40001 → C_sign_extended=0xFFFC0001; step low for 5 cycles → phase and outputs unchanged.
- Base address: branch with Ra=0, ba_mode=1 → SERout=0, zero_src=1; with ba_mode=0 → SERout=0x0001.
- Reset mid-sequence: clear low during RD1 → all outputs 0 and ir_ready=1 asynchronously; the next accept starts cleanly.
- Back-to-back: second ir_valid in the done cycle is accepted; ir_valid during RD0 is ignored (IR not re-latched).
- Scoreboard (macro on): deferred write to R7, then R-type reading Rb=7 → stall=1, SERout=0. wr_commit with wr_index=7 → stall drops next cycle, SERout=0x0080.

Source files
------------

// File: rtl/reg_select_seq.sv
// reg_select_seq
//   Sequenced register select/encode. Accepts an instruction word through a
//   valid/ready handshake, then walks its register phases (reads, then write)
//   as the datapath pulses step. Each phase drives a one-hot register-file
//   enable and the sign-extended immediate from latched state.
//
//   Optional build macro: SELECT_SCOREBOARD_EN
//     Adds a per-register busy vector. A deferred write marks its destination
//     busy, wr_commit clears it, and reads of a busy register stall.
//
// Ports
//   clock            rising-edge clock
//   clear            asynchronous active-low reset
//   IR / ir_valid    instruction word and its valid; ir_ready high only in idle
//   mode             00 R-type, 01 I-type, 10 store, 11 branch (latched with IR)
//   ba_mode          base-address semantics for read phases (live)
//   step             datapath consumed the current phase
//   SERin / SERout   one-hot register write / read enables
//   zero_src         read of R0 under ba_mode; datapath drives constant 0
//   phase            0 idle, 1 first read, 2 second read, 3 write
//   done             one-cycle pulse after the last phase
//   C_sign_extended  sign-extended immediate of the latched IR
//   stall            read phase blocked by a busy register
//   wr_defer / wr_commit / wr_index   scoreboard set/clear controls
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for ir_valid; phase 0
// RD0   | first read (Rb, or Ra for branch); phase 1
// RD1   | second read (Rc for R-type, Ra for store); phase 2
// WR    | write to Ra; phase 3
module reg_select_seq #(
   parameter int NUM_REGS  = 16,
   parameter int IR_WIDTH  = 32,
   parameter int RA_LSB    = 23,
   parameter int RB_LSB    = 19,
   parameter int RC_LSB    = 15,
   parameter int IMM_WIDTH = 19,
   localparam int REG_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [IR_WIDTH-1:0] IR,
   input  logic                ir_valid,
   output logic                ir_ready,
   input  logic [1:0]          mode,
   input  logic                ba_mode,
   input  logic                step,
   output logic [NUM_REGS-1:0] SERin,
   output logic [NUM_REGS-1:0] SERout,
   output logic                zero_src,
   output logic [1:0]          phase,
   output logic                done,
   output logic [IR_WIDTH-1:0] C_sign_extended,
   output logic                stall,
   input  logic                wr_defer,
   input  logic                wr_commit,
   input  logic [REG_BITS-1:0] wr_index
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD0  = 2'd1,
      S_RD1  = 2'd2,
      S_WR   = 2'd3
   } state_t;

   localparam logic [1:0] M_R  = 2'b00;
   localparam logic [1:0] M_I  = 2'b01;
   localparam logic [1:0] M_BR = 2'b11;

   state_t                 state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic [REG_BITS-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [IMM_WIDTH-1:0]   imm_q, imm_d;
   logic                   done_q, done_d;

   logic [REG_BITS-1:0]    sel_idx;
   logic [NUM_REGS-1:0]    sel_onehot;
   logic                   is_read, zero_sel, busy_sel, stall_int, adv;

   // Only the register fields and immediate are kept; the remaining IR bits
   // have no meaning to this block.
   logic unused_ir;
   assign unused_ir = ^IR;

`ifdef SELECT_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (state_q == S_WR && adv && wr_defer)
         busy_d[ra_q] = 1'b1;
      // Applied last so a same-edge clear of the same index wins.
      if (wr_commit)
         busy_d[wr_index] = 1'b0;
   end

   assign busy_sel = busy_q[sel_idx];
`else
   logic unused_sb;
   assign unused_sb = ^{wr_defer, wr_commit, wr_index};
   assign busy_sel  = 1'b0;
`endif

   always_comb begin
      case (state_q)
         S_RD0:   sel_idx = (mode_q == M_BR) ? ra_q : rb_q;
         S_RD1:   sel_idx = (mode_q == M_R)  ? rc_q : ra_q;
         default: sel_idx = ra_q;
      endcase
      sel_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel_idx;
      is_read    = (state_q == S_RD0) || (state_q == S_RD1);
      zero_sel   = is_read && ba_mode && (sel_idx == '0);
      // Constant-zero reads never touch the register file, so never stall.
      stall_int  = is_read && !zero_sel && busy_sel;
      adv        = step && !stall_int;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      imm_d   = imm_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ir_valid) begin
               state_d = S_RD0;
               mode_d  = mode;
               ra_d    = IR[RA_LSB +: REG_BITS];
               rb_d    = IR[RB_LSB +: REG_BITS];
               rc_d    = IR[RC_LSB +: REG_BITS];
               imm_d   = IR[IMM_WIDTH-1:0];
            end
         end
         S_RD0: begin
            if (adv) begin
               case (mode_q)
                  M_I:     state_d = S_WR;
                  M_BR: begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
                  default: state_d = S_RD1;
               endcase
            end
         end
         S_RD1: begin
            if (adv) begin
               if (mode_q == M_R) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            if (adv) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         imm_q   <= '0;
         done_q  <= 1'b0;
`ifdef SELECT_SCOREBOARD_EN
         busy_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         imm_q   <= imm_d;
         done_q  <= done_d;
`ifdef SELECT_SCOREBOARD_EN
         busy_q  <= busy_d;
`endif
      end
   end

   assign ir_ready        = (state_q == S_IDLE);
   assign phase           = state_q;
   assign done            = done_q;
   assign stall           = stall_int;
   assign zero_src        = zero_sel;
   assign SERout          = (is_read && !zero_sel && !stall_int) ? sel_onehot : '0;
   assign SERin           = (state_q == S_WR) ? sel_onehot : '0;
   assign C_sign_extended = {{(IR_WIDTH-IMM_WIDTH){imm_q[IMM_WIDTH-1]}}, imm_q};

endmodule
